ifetch_unit: RTL

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit_if.sv | 21 ++
 rtl/ifetch_unit.sv | 121 ++++++++++++
 2 files changed

// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and memory.
interface ifetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: a one-entry instruction buffer in front of a
// handshaked instruction memory. A buffer hit returns the word combinationally.
// A miss stalls the pipeline while the word is fetched. Flushes and timeouts
// abandon the outstanding fetch.
module ifetch_unit #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] NOP_WORD = 32'h00000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          pc,
  input  logic                 flush,
  output logic [31:0]          instr,
  output logic                 instr_valid,
  output logic                 stall,
  output logic                 misalign,
  output logic                 bus_err,
  ifetch_unit_if.master        imem
);

  localparam int unsigned   CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StWait, StDrain} state_e;

  state_e            state_q, state_d;
  logic              tag_valid_q, tag_valid_d;
  logic [31:0]       tag_addr_q, tag_addr_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       req_addr_q, req_addr_d;
  logic [CntW-1:0]   wcnt_q, wcnt_d;
  logic              bus_err_q, bus_err_d;
  logic              hit;

  // Hit detection and the pipeline-facing outputs.
  always_comb begin
    misalign       = (pc[1:0] != 2'b00);
    hit            = tag_valid_q && (tag_addr_q == pc) && !misalign && !flush;
    instr          = hit ? instr_q : NOP_WORD;
    instr_valid    = hit;
    stall          = !hit;
    bus_err        = bus_err_q;
    imem.imem_req  = (state_q != StIdle);
    imem.imem_addr = req_addr_q;
  end

  // Fetch FSM next state, buffer update and timeout tracking.
  always_comb begin
    state_d     = state_q;
    tag_valid_d = tag_valid_q;
    tag_addr_d  = tag_addr_q;
    instr_d     = instr_q;
    req_addr_d  = req_addr_q;
    wcnt_d      = wcnt_q;
    bus_err_d   = bus_err_q;

    case (state_q)
      StIdle: begin
        // Misaligned PCs and flush cycles never start a fetch.
        if (!hit && !misalign && !flush) begin
          state_d    = StWait;
          req_addr_d = pc;
          wcnt_d     = '0;
        end
      end
      StWait: begin
        if (imem.imem_ack) begin
          state_d = StIdle;
          if (!flush) begin
            tag_valid_d = 1'b1;
            tag_addr_d  = req_addr_q;
            instr_d     = imem.imem_rdata;
          end
        end else if (wcnt_q == CntLast) begin
          state_d   = StIdle;
          bus_err_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
          // The memory still owes us an ack; swallow it in DRAIN.
          if (flush) state_d = StDrain;
        end
      end
      StDrain: begin
        if (imem.imem_ack) begin
          state_d = StIdle;
        end else if (wcnt_q == CntLast) begin
          state_d   = StIdle;
          bus_err_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // A flush always wins over a same-cycle buffer fill.
    if (flush) tag_valid_d = 1'b0;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      tag_valid_q <= 1'b0;
      tag_addr_q  <= '0;
      instr_q     <= '0;
      req_addr_q  <= '0;
      wcnt_q      <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tag_valid_q <= tag_valid_d;
      tag_addr_q  <= tag_addr_d;
      instr_q     <= instr_d;
      req_addr_q  <= req_addr_d;
      wcnt_q      <= wcnt_d;
      bus_err_q   <= bus_err_d;
    end
  end

endmodule
